axi_engine_sched: RTL and testbench

AXI_ENGINE_SCHED -- requirements
Module: axi_engine_sched

---
 rtl/axi_engine_sched_pkg.sv | 18 +
 rtl/axi_engine_sched_rr_arbiter.sv | 37 +++
 rtl/axi_engine_sched.sv | 172 +++++++++++++++++
 tb/tb_axi_engine_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_engine_sched_pkg.sv
// Shared definitions for the AXI engine scheduler.
//   - FSM state encoding (2-bit, legacy-compatible localparam constants)
//   - width of the saturating timeout counter
//   - sat_inc: saturating increment used for err_count
package axi_engine_sched_pkg;

  localparam int ERR_CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_engine_sched_rr_arbiter.sv
// Round-robin grant selection.
// Ports:
//   req         - request vector, one bit per requester
//   ptr         - index of the last granted requester; search starts at ptr+1
//   grant       - one-hot grant (all zero when nothing requests)
//   grant_idx   - binary index of the granted requester
//   grant_valid - at least one request is present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Walk from the farthest candidate back to ptr+1 so the nearest
  // requesting index after ptr is the last one written and wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand        = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/axi_engine_sched.sv
// Shares one AXI read/write engine between NUM_REQ requesters, one
// operation at a time, with round-robin arbitration and a completion timeout.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   req_valid/req_write      - per-requester request and direction (1 = write)
//   req_addr/req_wdata       - packed per-requester operands (requester i at slice i)
//   req_ready                - one-hot acceptance pulse
//   rsp_valid/rsp_err/rsp_rdata - one-hot completion pulse, timeout flag, read data
//   start_wr/start_rd        - start pulses to the engine
//   write_addr/read_addr/write_data - operands to the engine
//   end_wr/end_rd/read_data  - engine completion levels and read data
//   busy                     - FSM not idle
//   err_count                - saturating timeout count
//   dbg_state                - current FSM state
//
// Handshake: a requester raises req_valid[i] with its operands and holds them
// until it sees req_ready[i] high for one cycle; that pulse is the acceptance.
// Exactly one rsp_valid[i] pulse follows per accepted request (unless reset
// intervenes). The engine sees one start_* pulse per operation and completes
// it with a rising edge on the matching end_* line.
module axi_engine_sched
  import axi_engine_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 33,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          start_wr,
  output logic                          start_rd,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [ADDR_WIDTH-1:0]         read_addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          end_wr,
  input  logic                          end_rd,
  input  logic [DATA_WIDTH-1:0]         read_data,
  output logic                          busy,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    op_onehot;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  end_wr_q;
  logic                  end_rd_q;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Only the end line matching the latched direction counts, and only on a
  // 0->1 transition, so a level left high by an earlier operation is ignored.
  logic done;
  assign done = op_write ? (end_wr & ~end_wr_q) : (end_rd & ~end_rd_q);

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      op_onehot  <= '0;
      op_write   <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      tmo_cnt    <= '0;
      end_wr_q   <= 1'b0;
      end_rd_q   <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      start_wr   <= 1'b0;
      start_rd   <= 1'b0;
      write_addr <= '0;
      read_addr  <= '0;
      write_data <= '0;
      err_count  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      start_wr  <= 1'b0;
      start_rd  <= 1'b0;
      end_wr_q  <= end_wr;
      end_rd_q  <= end_rd;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            req_ready <= grant;
            rr_ptr    <= grant_idx;
            op_onehot <= grant;
            op_write  <= req_write[grant_idx];
            op_addr   <= addr_arr[grant_idx];
            op_wdata  <= wdata_arr[grant_idx];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_wr <= op_write;
          start_rd <= ~op_write;
          if (op_write) begin
            write_addr <= op_addr;
            write_data <= op_wdata;
          end else begin
            read_addr <= op_addr;
          end
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion wins if it lands on the last allowed cycle.
          if (done) begin
            if (!op_write) rsp_rdata <= read_data;
            rsp_err <= 1'b0;
            state   <= ST_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_err   <= 1'b1;
            err_count <= sat_inc(err_count);
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_valid <= op_onehot;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_engine_sched.sv
// Bench for axi_engine_sched: randomized requests and engine timing, expected
// responses pushed into a queue by the driver, popped and compared by a monitor.
module tb_axi_engine_sched;

  localparam int NR = 4;
  localparam int AW = 33;
  localparam int DW = 64;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic             rsp_err, start_wr, start_rd, end_wr, end_rd, busy;
  logic [DW-1:0]    rsp_rdata, write_data, read_data;
  logic [AW-1:0]    write_addr, read_addr;
  logic [15:0]      err_count;
  logic [1:0]       dbg_state;

  axi_engine_sched #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .start_wr(start_wr), .start_rd(start_rd),
    .write_addr(write_addr), .read_addr(read_addr), .write_data(write_data),
    .end_wr(end_wr), .end_rd(end_rd), .read_data(read_data),
    .busy(busy), .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
    int            lat;
    logic [15:0]   ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_ptr;
  logic [15:0]   m_err;
  bit            pend  [NR];
  bit            p_wr  [NR];
  logic [AW-1:0] p_addr[NR];
  logic [DW-1:0] p_wdata[NR];

  function automatic int model_grant();
    for (int k = 1; k <= NR; k++) begin
      if (pend[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   grant_cyc = 0;
  int   mon_g;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (req_ready != '0) begin
        check("ready_has_expectation", 64'(grant_q.size() != 0), 64'd1);
        if (grant_q.size() != 0) begin
          mon_g = grant_q.pop_front();
          check("grant_onehot", 64'(req_ready), 64'(1 << mon_g));
        end
        grant_cyc = cyc;
      end
      if (start_wr || start_rd) begin
        check("start_exclusive", 64'(start_wr & start_rd), 64'd0);
        check("start_has_op", 64'(exp_q.size() != 0), 64'd1);
        check("busy_in_op", 64'(busy), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q[0];
          check("start_dir", 64'(start_wr), 64'(mon_e.wr));
          if (mon_e.wr) begin
            check("write_addr", 64'(write_addr), 64'(mon_e.addr));
            check("write_data", 64'(write_data), 64'(mon_e.wdata));
          end else begin
            check("read_addr", 64'(read_addr), 64'(mon_e.addr));
          end
        end
      end
      if (rsp_valid != '0) begin
        check("rsp_has_expectation", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_onehot", 64'(rsp_valid), 64'(1 << mon_e.idx));
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
          if (!mon_e.err && !mon_e.wr) check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
          check("latency", 64'(cyc - grant_cyc), 64'(mon_e.lat));
          check("err_count", 64'(err_count), 64'(mon_e.ecnt));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pend[i];
      req_write[i]           = p_wr[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
    end
  endtask

  task automatic new_ops(input int i);
    p_wr[i]    = 1'($urandom_range(0, 1));
    p_addr[i]  = {1'($urandom_range(0, 1)), $urandom};
    p_wdata[i] = {$urandom, $urandom};
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) pend[i] = 0;
    drive_reqs();
  endtask

  task automatic model_reset();
    m_ptr = NR - 1;
    m_err = 16'h0;
    exp_q.delete();
    grant_q.delete();
  endtask

  // One full operation. Called at a negedge with at least one request pending.
  // The matching end line goes low at start-relative step n1 and high at n2
  // (n1 < n2); step 0 is the negedge where start is seen.
  task automatic run_op(input bit keep, input int n1, input int n2);
    int            g, k;
    bit            prev, cur, line, seen;
    logic [DW-1:0] rd;
    exp_t          e;
    drive_reqs();
    g = model_grant();
    if (g < 0) return;
    m_ptr = g;
    rd    = {$urandom, $urandom};
    // Completion = first 0->1 of the line as seen on successive WAIT cycles.
    prev = p_wr[g] ? end_wr : end_rd;
    cur  = prev;
    k    = 0;
    for (int j = 0; j < TO; j++) begin
      if (j == n2) cur = 1'b1;
      else if (j == n1) cur = 1'b0;
      if (cur && !prev) begin
        k = j + 1;
        break;
      end
      prev = cur;
    end
    e.idx = g; e.wr = p_wr[g]; e.addr = p_addr[g]; e.wdata = p_wdata[g]; e.rdata = rd;
    if (k == 0) begin
      e.err = 1'b1;
      e.lat = 2 + TO;
      m_err = (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
    end else begin
      e.err = 1'b0;
      e.lat = 2 + k;
    end
    e.ecnt = m_err;
    grant_q.push_back(g);
    exp_q.push_back(e);
    // Wait for acceptance and start.
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        pend[g] = keep;
        new_ops(g);
        drive_reqs();
      end
      if (start_wr || start_rd) seen = 1'b1;
    end
    if (!seen) check("start_seen", 64'(start_wr | start_rd), 64'd1);
    // Engine behaviour.
    line = e.wr ? end_wr : end_rd;
    for (int j = 0; j < TO; j++) begin
      if (j > 0) @(negedge clk);
      if (j == n2) line = 1'b1;
      else if (j == n1) line = 1'b0;
      if (e.wr) begin
        end_wr = line;
        end_rd = 1'($urandom_range(0, 1));
      end else begin
        end_rd = line;
        end_wr = 1'($urandom_range(0, 1));
      end
      read_data = (j == n2) ? rd : {$urandom, $urandom};
      if (j == n2) break;
    end
    for (int t = 0; t < TO + 10 && rsp_valid == '0; t++) @(negedge clk);
    if (rsp_valid == '0) check("rsp_seen", 64'(rsp_valid), 64'(1 << g));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_start"}, 64'({start_wr, start_rd}), 64'd0);
    check({tag, "_write_addr"}, 64'(write_addr), 64'd0);
    check({tag, "_read_addr"}, 64'(read_addr), 64'd0);
    check({tag, "_write_data"}, 64'(write_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n1, n2;
    reset = 1'b1;
    end_wr = 1'b0; end_rd = 1'b0; read_data = '0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      new_ops(i);
    end
    drive_reqs();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Contention: all requesters held high -> 0,1,2,3,0
    for (int i = 0; i < NR; i++) pend[i] = 1;
    for (int r = 0; r < 5; r++) run_op(1'b1, 0, $urandom_range(1, 6));
    clear_reqs();

    // Single read from requester 2, end_rd rises 5 cycles after start_rd.
    end_rd = 1'b0; end_wr = 1'b0;
    @(negedge clk);
    pend[2] = 1; p_wr[2] = 1'b0; p_addr[2] = 33'h100;
    run_op(1'b0, 0, 5);

    // Timeout on a write: end_wr never rises.
    end_wr = 1'b0;
    pend[1] = 1; p_wr[1] = 1'b1;
    run_op(1'b0, 0, 1000);

    // Stale end_rd level: high before start, falls, then rises again.
    end_rd = 1'b1;
    @(negedge clk);
    pend[3] = 1; p_wr[3] = 1'b0;
    run_op(1'b0, 3, 6);

    // Boundary: completion on the last WAIT cycle, then one cycle too late.
    end_rd = 1'b0; end_wr = 1'b0;
    pend[0] = 1; p_wr[0] = 1'b0;
    run_op(1'b0, 0, TO - 1);
    end_rd = 1'b0; end_wr = 1'b0;
    pend[0] = 1; p_wr[0] = 1'b1;
    run_op(1'b0, 0, TO);

    // Randomized traffic.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          new_ops(i);
        end
      end
      if (model_grant() < 0) begin
        pend[$urandom_range(0, NR - 1)] = 1;
      end
      n2 = $urandom_range(0, 20);
      n1 = (n2 == 0) ? -1 : $urandom_range(0, n2 - 1);
      run_op(1'b0, n1, n2);
    end
    clear_reqs();

    // Reset during WAIT: operation abandoned, then requester 0 wins.
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1;
      new_ops(i);
    end
    drive_reqs();
    begin
      int   g;
      exp_t e;
      g = model_grant();
      m_ptr = g;
      e.idx = g; e.wr = p_wr[g]; e.addr = p_addr[g]; e.wdata = p_wdata[g];
      e.rdata = '0; e.err = 1'b0; e.lat = 0; e.ecnt = m_err;
      grant_q.push_back(g);
      exp_q.push_back(e);
      for (int t = 0; t < 8 && !(start_wr || start_rd); t++) @(negedge clk);
      if (!(start_wr || start_rd)) check("mid_reset_start_seen", 64'(start_wr | start_rd), 64'd1);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    end_wr = 1'b0; end_rd = 1'b0;
    clear_reqs();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    end
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1;
      new_ops(i);
    end
    run_op(1'b0, 0, 2);
    clear_reqs();

    // Saturation: err_count forced to all ones, further timeouts hold it.
    @(negedge clk);
    force dut.err_count = 16'hFFFF;
    #1;
    release dut.err_count;
    m_err = 16'hFFFF;
    @(negedge clk);
    check("err_count_forced", 64'(err_count), 64'hFFFF);
    end_wr = 1'b0; end_rd = 1'b0;
    pend[2] = 1; p_wr[2] = 1'b1;
    run_op(1'b0, 0, 1000);
    pend[3] = 1; p_wr[3] = 1'b0;
    run_op(1'b0, 0, 1000);
    clear_reqs();

    repeat (4) @(negedge clk);
    check("queues_drained", 64'(exp_q.size() + grant_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
